// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and status controller for an asynchronous FIFO.
// Keeps the binary read pointer for RAM addressing and a registered Gray copy that is sent to the write domain.
module fifo_rptr_empty #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd_en,
    input  logic [ADDRSIZE:0]   i_wptr_sync,
    input  logic                i_err_clr,
    output logic [ADDRSIZE:0]   o_rptr,
    output logic [ADDRSIZE-1:0] o_raddr,
    output logic                o_rd_ack,
    output logic                o_empty,
    output logic                o_almost_empty,
    output logic [ADDRSIZE:0]   o_rd_level,
    output logic                o_underflow
);

    localparam logic [ADDRSIZE:0] AE_LIMIT = (ADDRSIZE+1)'(AE_THRESH);

    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rgray_q, rgray_d;
    logic [ADDRSIZE:0] level_q, level_d;
    logic              empty_q, empty_d;
    logic              ae_q, ae_d;
    logic              ack_q, ack_d;
    logic              uflow_q, uflow_d;
    logic [ADDRSIZE:0] wbin;
    logic              rd_fire;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_wbin
            assign wbin[gi] = ^i_wptr_sync[ADDRSIZE:gi];
        end
    endgenerate

    // Reads while empty are dropped; the empty flag here is the registered one.
    assign rd_fire = i_rd_en & ~empty_q;

    always_comb begin
        rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, rd_fire};
        rgray_d = (rbin_d >> 1) ^ rbin_d;
        empty_d = (rgray_d == i_wptr_sync);
        level_d = wbin - rbin_d;
        ae_d    = (level_d <= AE_LIMIT);
        ack_d   = rd_fire;
        uflow_d = (i_rd_en & empty_q) | (uflow_q & ~i_err_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            ack_q   <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            level_q <= level_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
            ack_q   <= ack_d;
            uflow_q <= uflow_d;
        end
    end

    assign o_rptr         = rgray_q;
    assign o_raddr        = rbin_q[ADDRSIZE-1:0];
    assign o_rd_ack       = ack_q;
    assign o_empty        = empty_q;
    assign o_almost_empty = ae_q;
    assign o_rd_level     = level_q;
    assign o_underflow    = uflow_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty (ADDRSIZE=4, AE_THRESH=2).
// Early vectors use hand-computed constants; the streaming phase tracks read/write counts.
module tb_fifo_rptr_empty;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_rd_en;
    logic [4:0] i_wptr_sync;
    logic       i_err_clr;
    logic [4:0] o_rptr;
    logic [3:0] o_raddr;
    logic       o_rd_ack;
    logic       o_empty;
    logic       o_almost_empty;
    logic [4:0] o_rd_level;
    logic       o_underflow;

    int total = 0;
    int bad   = 0;
    int exp_r, exp_w;
    bit exp_empty, exp_uf;
    bit wrapped = 0;

    fifo_rptr_empty #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rd_en        (i_rd_en),
        .i_wptr_sync    (i_wptr_sync),
        .i_err_clr      (i_err_clr),
        .o_rptr         (o_rptr),
        .o_raddr        (o_raddr),
        .o_rd_ack       (o_rd_ack),
        .o_empty        (o_empty),
        .o_almost_empty (o_almost_empty),
        .o_rd_level     (o_rd_level),
        .o_underflow    (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int x);
        logic [4:0] b;
        b = x[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
        $display("t=%0t rptr=%b raddr=%0d ack=%b empty=%b ae=%b level=%0d uf=%b",
                 $time, o_rptr, o_raddr, o_rd_ack, o_empty, o_almost_empty, o_rd_level, o_underflow);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rptr"},  o_rptr, 0);
        check({tag, "_raddr"}, o_raddr, 0);
        check({tag, "_ack"},   o_rd_ack, 0);
        check({tag, "_empty"}, o_empty, 1);
        check({tag, "_ae"},    o_almost_empty, 1);
        check({tag, "_level"}, o_rd_level, 0);
        check({tag, "_uf"},    o_underflow, 0);
    endtask

    // One cycle: optional read, advance write count by wadv, optional error clear.
    task automatic cyc(input string tag, input bit rd, input int wadv, input bit clr);
        bit fire;
        int lvl;
        i_rd_en     = rd;
        i_err_clr   = clr;
        exp_w       = exp_w + wadv;
        i_wptr_sync = gray(exp_w);
        fire        = rd && !exp_empty;
        exp_uf      = (rd && exp_empty) || (exp_uf && !clr);
        step();
        exp_r     = exp_r + (fire ? 1 : 0);
        lvl       = (exp_w - exp_r) & 31;
        exp_empty = (lvl == 0);
        check({tag, "_rptr"},  o_rptr, gray(exp_r));
        check({tag, "_raddr"}, o_raddr, exp_r & 15);
        check({tag, "_ack"},   o_rd_ack, fire);
        check({tag, "_empty"}, o_empty, exp_empty);
        check({tag, "_level"}, o_rd_level, lvl);
        check({tag, "_ae"},    o_almost_empty, lvl <= 2);
        check({tag, "_uf"},    o_underflow, exp_uf);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_rd_en     = 1'b0;
        i_wptr_sync = 5'b00000;
        i_err_clr   = 1'b0;
        repeat (3) step();
        check_reset("rst_hold");
        i_rst_n = 1'b1;
        step();
        check_reset("rst_rel");

        // Fill: write pointer Gray 00010 = three entries
        i_wptr_sync = 5'b00010;
        step();
        check("fill_empty", o_empty, 0);
        check("fill_level", o_rd_level, 3);
        check("fill_ae",    o_almost_empty, 0);
        check("fill_rptr",  o_rptr, 5'b00000);

        i_rd_en = 1'b1;
        step();
        check("rd1_rptr", o_rptr, 5'b00001);
        check("rd1_raddr", o_raddr, 1);
        check("rd1_level", o_rd_level, 2);
        check("rd1_ae", o_almost_empty, 1);
        check("rd1_ack", o_rd_ack, 1);
        check("rd1_empty", o_empty, 0);
        step();
        check("rd2_rptr", o_rptr, 5'b00011);
        check("rd2_raddr", o_raddr, 2);
        check("rd2_level", o_rd_level, 1);
        check("rd2_ack", o_rd_ack, 1);
        step();
        check("rd3_rptr", o_rptr, 5'b00010);
        check("rd3_raddr", o_raddr, 3);
        check("rd3_level", o_rd_level, 0);
        check("rd3_ack", o_rd_ack, 1);
        check("rd3_empty", o_empty, 1);
        check("rd3_uf", o_underflow, 0);

        // Read while empty: ignored, underflow latches
        step();
        check("uf_rptr", o_rptr, 5'b00010);
        check("uf_raddr", o_raddr, 3);
        check("uf_ack", o_rd_ack, 0);
        check("uf_set", o_underflow, 1);
        i_rd_en = 1'b0;
        step();
        check("uf_hold", o_underflow, 1);
        i_err_clr = 1'b1;
        step();
        check("uf_clr", o_underflow, 0);
        i_rd_en = 1'b1;
        step();
        check("uf_setwins", o_underflow, 1);
        check("uf_setwins_ack", o_rd_ack, 0);
        i_rd_en   = 1'b0;
        i_err_clr = 1'b0;

        exp_r = 3; exp_w = 3; exp_empty = 1; exp_uf = 1;
        cyc("clr", 0, 0, 1);

        // Simultaneous read and write at level 1
        cyc("sim_pre", 0, 1, 0);
        check("sim_pre_level", o_rd_level, 1);
        cyc("sim", 1, 1, 0);
        check("sim_empty", o_empty, 0);
        check("sim_level", o_rd_level, 1);

        // Fill to depth 16
        for (int i = 0; i < 15; i++) cyc("fill16", 0, 1, 0);
        check("full_level", o_rd_level, 16);
        check("full_ae", o_almost_empty, 0);
        check("full_empty", o_empty, 0);

        for (int i = 0; i < 8; i++) cyc("drain8", 1, 0, 0);

        // Stream through the pointer wrap
        for (int i = 0; i < 40; i++) begin
            cyc("stream", 1, 1, 0);
            if ((exp_r & 31) == 31) check("wrap_pre_rptr", o_rptr, 5'b10000);
            if ((exp_r & 31) == 0 && !wrapped) begin
                wrapped = 1;
                check("wrap_rptr", o_rptr, 5'b00000);
                check("wrap_raddr", o_raddr, 0);
            end
        end
        check("wrap_seen", wrapped, 1);

        for (int i = 0; i < 8; i++) cyc("drain", 1, 0, 0);
        check("drain_empty", o_empty, 1);

        // Asynchronous reset while holding five entries
        cyc("pre_rst", 0, 5, 0);
        check("pre_rst_level", o_rd_level, 5);
        #2;
        i_rst_n     = 1'b0;
        i_wptr_sync = 5'b00000;
        #1;
        check_reset("async_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rptr_empty.md
# fifo_rptr_empty

Read-side pointer and empty-flag controller for the asynchronous FIFO, clocked entirely in the read domain. It owns the read pointer (binary for RAM addressing, Gray for crossing), accepts the write pointer after it has been Gray-synchronized into the read clock, and produces registered empty, almost-empty and fill-level status. Its Gray pointer output is the value the write domain synchronizes for its own full logic.

## Interface
- ADDRSIZE, 4, RAM address width; FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AE_THRESH, 2, almost-empty threshold in entries (0..2^ADDRSIZE).

Ports:
- i_clk  input  1  read-domain clock.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_rd_en  input  1  read request from consumer.
- i_wptr_sync  input  ADDRSIZE+1  write pointer, Gray-coded, already synchronized into i_clk.
- i_err_clr  input  1  clears sticky underflow flag.
- o_rptr  output  ADDRSIZE+1  read pointer, Gray-coded, registered; sent to write domain.
- o_raddr  output  ADDRSIZE  RAM read address = low ADDRSIZE bits of binary read pointer.
- o_rd_ack  output  1  registered; high the cycle after an accepted read (sync-read RAM data valid).
- o_empty  output  1  registered empty flag.
- o_almost_empty  output  1  registered; level <= AE_THRESH.
- o_rd_level  output  ADDRSIZE+1  registered entry count, 0..2^ADDRSIZE.
- o_underflow  output  1  sticky: read requested while empty.

## Operation
- Internal rbin (ADDRSIZE+1 bits, binary); o_rptr is its Gray image, held in its own register (never decoded combinationally at the output).
- rd_fire = i_rd_en & ~o_empty. Reads while empty are ignored: no pointer change, no ack.
- rbin_next = rbin + rd_fire (mod 2^(ADDRSIZE+1)); rgray_next = (rbin_next >> 1) ^ rbin_next.
- Every cycle: rbin <= rbin_next; o_rptr <= rgray_next.
- Empty: o_empty <= (rgray_next == i_wptr_sync). Compare is on full ADDRSIZE+1-bit Gray values (MSB distinguishes wrap).
- Level: wbin = Gray-to-binary(i_wptr_sync); level_next = (wbin - rbin_next) mod 2^(ADDRSIZE+1); o_rd_level <= level_next; o_almost_empty <= (level_next <= AE_THRESH).
- o_rd_ack <= rd_fire.
- Underflow: set on i_rd_en & o_empty; cleared by i_err_clr; set has priority if both same cycle.
- Simultaneous read and write-pointer advance: both applied in one cycle; level unchanged net, empty stays low.
- Wrap-around: rbin rolls 2^(ADDRSIZE+1)-1 -> 0; o_raddr rolls every 2^ADDRSIZE reads; Gray MSB toggles at each half wrap.
- Pessimism is by design: synchronized write pointer lags, so empty/level may understate contents, never overstate.

## Timing
- Reset (async assert, sync-domain release): o_rptr=0, o_raddr=0, o_rd_ack=0, o_empty=1, o_almost_empty=1, o_rd_level=0, o_underflow=0.
- Reset mid-operation clears all state immediately; i_wptr_sync is expected to reset in the same event.
- All outputs change only on i_clk rising edge (o_raddr follows registered rbin).
- Accepted read at edge N: o_raddr/o_rptr advance at N, o_rd_ack high for cycle after N, o_empty asserts at N if that was the last entry (no extra cycle).
- i_wptr_sync change visible on o_empty/o_rd_level/o_almost_empty one edge later.
- o_rptr changes at most one bit per edge.

## Test plan
- Reset: hold i_rst_n=0 -> all outputs at reset values; o_empty=1, o_rd_level=0.
- Fill/drain (ADDRSIZE=4, AE_THRESH=2): i_wptr_sync=5'b00010 (bin 3) -> next edge o_empty=0, level=3, almost_empty=0; three reads -> o_rptr 00001,00011,00010, o_raddr 1,2,3, level 2,1,0, almost_empty=1 after first, o_empty=1 at third edge, o_rd_ack high three cycles.
- Underflow: i_rd_en=1 while empty -> pointer unchanged, o_rd_ack=0, o_underflow=1 held until i_err_clr pulse; set wins on coincident clear+underflow.
- Simultaneous: level=1, read while i_wptr_sync advances by 1 -> o_empty stays 0, level stays 1.
- Wrap: stream 40 writes/reads -> rbin passes 31->0, o_rptr 5'b10000->5'b00000, o_raddr 15->0; level and empty correct throughout; full level 16 reported when wbin-rbin=16.
- Mid-operation reset with level 5 -> all outputs return to reset values asynchronously.
